serial_subtract_sequencer: RTL and testbench



---
 rtl/serial_subtract_sequencer_pkg.sv | 18 +
 rtl/serial_subtract_sequencer_if.sv | 25 ++
 rtl/serial_subtract_datapath.sv | 82 ++++++++
 rtl/serial_subtract_sequencer.sv | 88 ++++++++
 tb/tb_serial_subtract_sequencer.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/serial_subtract_sequencer_pkg.sv
// Shared definitions for the serial subtract sequencer: controller state
// encoding, digit width and the digit-counter width helper.
package serial_subtract_sequencer_pkg;

   localparam int unsigned DIGIT = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Digit counter needs clog2(n) bits, but never fewer than one.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_subtract_sequencer_if.sv
// Request/result bus of the serial subtract sequencer.
interface serial_subtract_sequencer_if #(
   parameter int unsigned WIDTH = 8
) ();

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             borrow_in;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] diff;
   logic             borrow_out;

   modport master (
      output start, a, b, borrow_in,
      input  busy, done, diff, borrow_out
   );

   modport slave (
      input  start, a, b, borrow_in,
      output busy, done, diff, borrow_out
   );

endinterface

// File: rtl/serial_subtract_datapath.sv
// Datapath of the serial subtract sequencer: operand and result shift
// registers, chained borrow, digit counter and the held result registers.
module serial_subtract_datapath
   import serial_subtract_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             shift,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             borrow_in,
   input  logic             d1,
   input  logic             d0,
   input  logic             b2,
   output logic [DIGIT-1:0] x_dig,
   output logic [DIGIT-1:0] y_dig,
   output logic             brw,
   output logic             last,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out
);

   localparam int unsigned N  = WIDTH / DIGIT;
   localparam int unsigned CW = cnt_width(N);

   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;
   logic [WIDTH-1:0] res_sh;
   logic [WIDTH-1:0] res_next;
   logic [CW-1:0]    cnt;

   // New digit enters at the top; a single-digit result is just the digit.
   generate
      if (WIDTH == DIGIT) begin : g_one_digit
         assign res_next = {d1, d0};
      end else begin : g_multi_digit
         assign res_next = {d1, d0, res_sh[WIDTH-1:DIGIT]};
      end
   endgenerate

   assign x_dig = a_sh[DIGIT-1:0];
   assign y_dig = b_sh[DIGIT-1:0];
   assign last  = (cnt == CW'(N - 1));

   // Working registers: capture operands on load, advance one digit per shift.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sh   <= '0;
         b_sh   <= '0;
         res_sh <= '0;
         brw    <= 1'b0;
         cnt    <= '0;
      end else if (load) begin
         a_sh   <= a;
         b_sh   <= b;
         res_sh <= '0;
         brw    <= borrow_in;
         cnt    <= '0;
      end else if (shift) begin
         a_sh   <= a_sh >> DIGIT;
         b_sh   <= b_sh >> DIGIT;
         res_sh <= res_next;
         brw    <= b2;
         cnt    <= cnt + 1'b1;
      end
   end

   // Published result: updated only when the last digit completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         diff       <= '0;
         borrow_out <= 1'b0;
      end else if (shift && last) begin
         diff       <= res_next;
         borrow_out <= b2;
      end
   end

endmodule

// File: rtl/serial_subtract_sequencer.sv
// Serial subtract sequencer: accepts a WIDTH-bit subtraction on start and
// streams it LSB-first through an external 2-bit ripple subtractor slice.
module serial_subtract_sequencer
   import serial_subtract_sequencer_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   serial_subtract_sequencer_if.slave bus,
   output logic                       slice_x1,
   output logic                       slice_x0,
   output logic                       slice_y1,
   output logic                       slice_y0,
   output logic                       slice_b0,
   input  logic                       slice_d1,
   input  logic                       slice_d0,
   input  logic                       slice_b2
);

   state_t           state;
   state_t           state_next;
   logic             load;
   logic             shift;
   logic             last;
   logic             brw;
   logic [DIGIT-1:0] x_dig;
   logic [DIGIT-1:0] y_dig;

   serial_subtract_datapath #(
      .WIDTH (WIDTH)
   ) u_datapath (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .shift      (shift),
      .a          (bus.a),
      .b          (bus.b),
      .borrow_in  (bus.borrow_in),
      .d1         (slice_d1),
      .d0         (slice_d0),
      .b2         (slice_b2),
      .x_dig      (x_dig),
      .y_dig      (y_dig),
      .brw        (brw),
      .last       (last),
      .diff       (bus.diff),
      .borrow_out (bus.borrow_out)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Next-state logic: start is honoured only in IDLE.
   always_comb begin
      state_next = state;
      unique case (state)
         IDLE:    if (bus.start) state_next = RUN;
         RUN:     if (last)      state_next = DONE;
         DONE:                   state_next = IDLE;
         default:                state_next = IDLE;
      endcase
   end

   // Outputs decoded from the state register only; slice inputs idle at 0.
   always_comb begin
      load     = (state == IDLE) && bus.start;
      shift    = (state == RUN);
      bus.busy = (state == RUN);
      bus.done = (state == DONE);
      slice_x1 = 1'b0;
      slice_x0 = 1'b0;
      slice_y1 = 1'b0;
      slice_y0 = 1'b0;
      slice_b0 = 1'b0;
      if (state == RUN) begin
         slice_x1 = x_dig[1];
         slice_x0 = x_dig[0];
         slice_y1 = y_dig[1];
         slice_y0 = y_dig[0];
         slice_b0 = brw;
      end
   end

endmodule

// File: tb/tb_serial_subtract_sequencer.sv
// Bench for serial_subtract_sequencer with a 2-bit ripple subtractor slice
// wired to the slice ports.
module tb_serial_subtract_sequencer;

   localparam int unsigned WIDTH = 8;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   serial_subtract_sequencer_if #(.WIDTH(WIDTH)) bus ();

   logic slice_x1, slice_x0, slice_y1, slice_y0, slice_b0;
   logic slice_d1, slice_d0, slice_b2;
   logic slice_bm;

   // 2-bit ripple subtractor slice (x - y - b0).
   assign slice_d0 = slice_x0 ^ slice_y0 ^ slice_b0;
   assign slice_bm = (~slice_x0 & slice_y0) | (~(slice_x0 ^ slice_y0) & slice_b0);
   assign slice_d1 = slice_x1 ^ slice_y1 ^ slice_bm;
   assign slice_b2 = (~slice_x1 & slice_y1) | (~(slice_x1 ^ slice_y1) & slice_bm);

   serial_subtract_sequencer #(.WIDTH(WIDTH)) dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus),
      .slice_x1 (slice_x1),
      .slice_x0 (slice_x0),
      .slice_y1 (slice_y1),
      .slice_y0 (slice_y0),
      .slice_b0 (slice_b0),
      .slice_d1 (slice_d1),
      .slice_d0 (slice_d0),
      .slice_b2 (slice_b2)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       bin;
      logic [7:0] d;
      logic       bo;
   } vec_t;

   localparam int NV = 10;
   vec_t vecs [NV];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [4:0] slice_vec();
      return {slice_x1, slice_x0, slice_y1, slice_y0, slice_b0};
   endfunction

   // One full operation; inputs are scrambled after the start edge.
   task automatic do_op(input logic [7:0] ta, input logic [7:0] tbv, input logic tbin,
                        output logic [7:0] rd, output logic rbo,
                        output int lat, output int nbusy, output int ndone);
      step();
      bus.a = ta; bus.b = tbv; bus.borrow_in = tbin; bus.start = 1'b1;
      step();
      bus.start = 1'b0; bus.a = ~ta; bus.b = ~tbv; bus.borrow_in = ~tbin;
      lat = 1; nbusy = bus.busy ? 1 : 0; ndone = 0;
      while (!bus.done && lat < 20) begin
         step();
         lat++;
         if (bus.busy) nbusy++;
      end
      if (bus.done) ndone++;
      rd = bus.diff; rbo = bus.borrow_out;
      step();
      if (bus.done) ndone++;
   endtask

   initial begin
      logic [7:0] rd;
      logic       rbo;
      int         lat, nbusy, ndone;

      vecs[0] = '{8'hA5, 8'h3C, 1'b0, 8'h69, 1'b0};
      vecs[1] = '{8'h10, 8'h20, 1'b0, 8'hF0, 1'b1};
      vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
      vecs[3] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0};
      vecs[4] = '{8'h55, 8'h11, 1'b0, 8'h44, 1'b0};
      vecs[5] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0};
      vecs[6] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
      vecs[7] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1};
      vecs[8] = '{8'h01, 8'h00, 1'b1, 8'h00, 1'b0};
      vecs[9] = '{8'hC3, 8'h41, 1'b1, 8'h81, 1'b0};

      rst = 1'b1;
      bus.start = 1'b0; bus.a = '0; bus.b = '0; bus.borrow_in = 1'b0;
      #12;
      chk("reset busy", bus.busy, 0);
      chk("reset done", bus.done, 0);
      chk("reset diff", bus.diff, 0);
      chk("reset borrow_out", bus.borrow_out, 0);
      chk("reset slice", slice_vec(), 0);
      step();
      rst = 1'b0;

      // Table-driven operations.
      for (int i = 0; i < NV; i++) begin
         do_op(vecs[i].a, vecs[i].b, vecs[i].bin, rd, rbo, lat, nbusy, ndone);
         chk($sformatf("vec%0d diff", i), rd, vecs[i].d);
         chk($sformatf("vec%0d borrow_out", i), rbo, vecs[i].bo);
         chk($sformatf("vec%0d latency", i), lat, 5);
         chk($sformatf("vec%0d busy cycles", i), nbusy, 4);
         chk($sformatf("vec%0d done pulses", i), ndone, 1);
      end

      // Start reasserted on the 2nd busy cycle must be ignored.
      step();
      bus.a = 8'h55; bus.b = 8'h11; bus.borrow_in = 1'b0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      bus.a = 8'h00; bus.b = 8'hFF; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      lat = 3; ndone = 0;
      while (!bus.done && lat < 20) begin
         step();
         lat++;
      end
      if (bus.done) ndone++;
      chk("ignored-start diff", bus.diff, 8'h44);
      chk("ignored-start borrow_out", bus.borrow_out, 0);
      chk("ignored-start latency", lat, 5);
      step();
      if (bus.done) ndone++;
      chk("ignored-start done pulses", ndone, 1);
      chk("ignored-start idle after", bus.busy, 0);

      // Reset on the 3rd busy cycle: everything clears, no done follows.
      step();
      bus.a = 8'h80; bus.b = 8'h01; bus.borrow_in = 1'b0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      step();
      step();
      chk("pre-reset busy", bus.busy, 1);
      rst = 1'b1;
      #1;
      chk("mid-reset busy", bus.busy, 0);
      chk("mid-reset done", bus.done, 0);
      chk("mid-reset diff", bus.diff, 0);
      chk("mid-reset borrow_out", bus.borrow_out, 0);
      chk("mid-reset slice", slice_vec(), 0);
      step();
      rst = 1'b0;
      ndone = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         if (bus.done || bus.busy) ndone++;
      end
      chk("post-reset quiet", ndone, 0);
      do_op(8'h80, 8'h01, 1'b0, rd, rbo, lat, nbusy, ndone);
      chk("post-reset diff", rd, 8'h7F);
      chk("post-reset borrow_out", rbo, 0);
      chk("post-reset done pulses", ndone, 1);

      // Digit stream, start during DONE ignored, back-to-back from IDLE.
      step();
      bus.a = 8'hA5; bus.b = 8'h3C; bus.borrow_in = 1'b0; bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      chk("digit0 slice", slice_vec(), 5'b01000);
      step();
      chk("digit1 slice", slice_vec(), 5'b01110);
      step();
      chk("digit2 slice", slice_vec(), 5'b10111);
      step();
      chk("digit3 slice", slice_vec(), 5'b10001);
      step();
      chk("b2b first done", bus.done, 1);
      chk("b2b first diff", bus.diff, 8'h69);
      chk("done slice", slice_vec(), 0);
      bus.a = 8'h10; bus.b = 8'h20; bus.borrow_in = 1'b0; bus.start = 1'b1;
      step();
      chk("start in DONE ignored", bus.busy, 0);
      step();
      bus.start = 1'b0;
      chk("b2b second busy", bus.busy, 1);
      lat = 1;
      while (!bus.done && lat < 20) begin
         chk($sformatf("b2b diff hold %0d", lat), bus.diff, 8'h69);
         step();
         lat++;
      end
      chk("b2b second latency", lat, 5);
      chk("b2b second diff", bus.diff, 8'hF0);
      chk("b2b second borrow_out", bus.borrow_out, 1);
      step();
      chk("b2b result held", bus.diff, 8'hF0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
